// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder in front of a small
// in-order result queue, valid/ready handshaked on both sides.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_unknown
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_SH   = 3'd6;

  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v
  );
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_sh;
  logic            w_ld, w_opi, w_opw;
  logic            w_st, w_br, w_up, w_jal;
  logic [XLEN-1:0] w_sh5, w_sh6;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_unk;

  assign w_op  = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_sh  = (w_f3 == 3'b001) ||
                 (w_f3 == 3'b101);
  assign w_ld  = (w_op == 7'b0000011) ||
                 (w_op == 7'b1100111);
  assign w_opi = (w_op == 7'b0010011);
  assign w_opw = RV64 &&
                 (w_op == 7'b0011011);
  assign w_st  = (w_op == 7'b0100011);
  assign w_br  = (w_op == 7'b1100011);
  assign w_up  = (w_op == 7'b0110111) ||
                 (w_op == 7'b0010111);
  assign w_jal = (w_op == 7'b1101111);
  assign w_sh5 = {{(XLEN-5){1'b0}},
                  in_inst[24:20]};
  assign w_sh6 = {{(XLEN-6){1'b0}},
                  in_inst[25:20]};

  always_comb begin
    w_imm = '0;
    w_fmt = F_NONE;
    w_unk = 1'b0;
    unique case (1'b1)
      w_ld: begin
        w_fmt = F_I;
        w_imm = sx({{20{in_inst[31]}},
                    in_inst[31:20]});
      end
      w_opi, w_opw: begin
        if (w_sh) begin
          // RV64 OP-IMM takes a 6-bit shamt; OP-IMM-32 stays 5-bit
          w_fmt = F_SH;
          w_imm = (w_opi && RV64) ? w_sh6
                                  : w_sh5;
        end else begin
          w_fmt = F_I;
          w_imm = sx({{20{in_inst[31]}},
                      in_inst[31:20]});
        end
      end
      w_st: begin
        w_fmt = F_S;
        w_imm = sx({{20{in_inst[31]}},
                    in_inst[31:25],
                    in_inst[11:7]});
      end
      w_br: begin
        w_fmt = F_B;
        w_imm = sx({{20{in_inst[31]}},
                    in_inst[7],
                    in_inst[30:25],
                    in_inst[11:8], 1'b0});
      end
      w_up: begin
        w_fmt = F_U;
        w_imm = sx({in_inst[31:12], 12'b0});
      end
      w_jal: begin
        w_fmt = F_J;
        w_imm = sx({{12{in_inst[31]}},
                    in_inst[19:12],
                    in_inst[20],
                    in_inst[30:21], 1'b0});
      end
      default: w_unk = 1'b1;
    endcase
  end

  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [2:0]       r_fmt [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic             r_unk [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_rdy;
  logic             w_push, w_pop;
  logic [CW-1:0]    w_cnt_nx;

  assign w_push   = in_valid & r_rdy;
  assign w_pop    = out_valid & out_ready;
  assign w_cnt_nx = r_cnt + CW'(w_push)
                          - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_imm[i] <= '0;
        r_fmt[i] <= '0;
        r_tag[i] <= '0;
        r_unk[i] <= 1'b0;
      end
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_imm[r_wp] <= w_imm;
        r_fmt[r_wp] <= w_fmt;
        r_tag[r_wp] <= in_tag;
        r_unk[r_wp] <= w_unk;
        r_wp        <= nxt(r_wp);
      end
      if (w_pop)
        r_rp <= nxt(r_rp);
      r_cnt <= w_cnt_nx;
      r_rdy <= (w_cnt_nx < CW'(DEPTH));
    end
  end

  assign in_ready    = r_rdy;
  assign out_valid   = (r_cnt != '0);
  assign out_imm     = out_valid ? r_imm[r_rp]
                                 : '0;
  assign out_fmt     = out_valid ? r_fmt[r_rp]
                                 : '0;
  assign out_tag     = out_valid ? r_tag[r_rp]
                                 : '0;
  assign out_unknown = out_valid & r_unk[r_rp];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared stimulus,
// checked against a queue model with an arithmetic decoder.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [4:0]  in_tag = '0;

  logic        rdy32, v32, unk32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [4:0]  tag32;
  logic        rdy64, v64, unk64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [4:0]  tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .XLEN(32), .DEPTH(DEPTH), .TAG_W(5)
  ) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32),
    .out_tag(tag32), .out_unknown(unk32)
  );

  imm_gen_pipe #(
    .XLEN(64), .DEPTH(DEPTH), .TAG_W(5)
  ) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64),
    .out_tag(tag64), .out_unknown(unk64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  tag;
    logic        unk;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];
  bit   m_rdy = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_dec(
    input logic [31:0] w,
    input logic [4:0]  tag,
    input bit          rv64
  );
    ent_t   e;
    longint v;
    v = 0;
    e.fmt = 3'd0;
    e.unk = 1'b0;
    e.tag = tag;
    case (w[6:0])
      7'h03, 7'h67: begin
        e.fmt = 3'd1;
        v = $signed(w[31:20]);
      end
      7'h13, 7'h1B: begin
        if (w[6:0] == 7'h1B && !rv64) begin
          e.unk = 1'b1;
        end else if (w[14:12] == 3'd1 ||
                     w[14:12] == 3'd5) begin
          e.fmt = 3'd6;
          if (rv64 && w[6:0] == 7'h13)
            v = w[25:20];
          else
            v = w[24:20];
        end else begin
          e.fmt = 3'd1;
          v = $signed(w[31:20]);
        end
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = $signed({w[31:25], w[11:7]});
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = $signed({w[31], w[7], w[30:25],
                     w[11:8], 1'b0});
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = $signed({w[31:12], 12'h000});
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = $signed({w[31], w[19:12], w[20],
                     w[30:21], 1'b0});
      end
      default: e.unk = 1'b1;
    endcase
    e.imm = rv64 ? v : {32'h0, v[31:0]};
    return e;
  endfunction

  task automatic check_state();
    ent_t e32, e64;
    e32 = '{imm: 0, fmt: 0, tag: 0, unk: 0};
    e64 = e32;
    if (q32.size() != 0) e32 = q32[0];
    if (q64.size() != 0) e64 = q64[0];
    chk("rdy32", rdy32, m_rdy);
    chk("rdy64", rdy64, m_rdy);
    chk("vld32", v32, q32.size() != 0);
    chk("vld64", v64, q64.size() != 0);
    chk("imm32", imm32, e32.imm);
    chk("imm64", imm64, e64.imm);
    chk("fmt32", fmt32, e32.fmt);
    chk("fmt64", fmt64, e64.fmt);
    chk("tag32", tag32, e32.tag);
    chk("tag64", tag64, e64.tag);
    chk("unk32", unk32, e32.unk);
    chk("unk64", unk64, e64.unk);
  endtask

  // called at a falling edge: check, drive, model the next rising edge
  task automatic cycle(input logic        v,
                       input logic [31:0] w,
                       input logic [4:0]  t,
                       input logic        ordy,
                       input logic        fl);
    bit push, pop;
    check_state();
    in_valid  = v;
    in_inst   = w;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    push = v && m_rdy;
    pop  = (q32.size() != 0) && ordy;
    if (fl) begin
      q32.delete();
      q64.delete();
      m_rdy = 1'b1;
    end else begin
      if (pop) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (push) begin
        q32.push_back(ref_dec(w, t, 1'b0));
        q64.push_back(ref_dec(w, t, 1'b1));
      end
      m_rdy = (q32.size() < DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 5'd0, ordy, 1'b0);
  endtask

  logic [6:0] ops [10] = '{
    7'h03, 7'h67, 7'h13, 7'h1B, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6F, 7'h33
  };

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0)
      w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_state();

    // basic decodes, consumer always ready
    cycle(1'b1, 32'hFFF00093, 5'd1, 1'b1, 1'b0);
    chk("addi_imm", imm32, 32'hFFFFFFFF);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_fmt", fmt32, 3'd1);
    chk("addi_tag", tag32, 5'd1);
    cycle(1'b1, 32'hFE112E23, 5'd2, 1'b1, 1'b0);
    chk("sw_imm", imm32, 32'hFFFFFFFC);
    chk("sw_fmt", fmt32, 3'd2);
    cycle(1'b1, 32'hFE000CE3, 5'd3, 1'b1, 1'b0);
    chk("beq_imm", imm32, 32'hFFFFFFF8);
    chk("beq_fmt", fmt32, 3'd3);
    cycle(1'b1, 32'h0000000B, 5'd4, 1'b1, 1'b0);
    chk("unk_flag", unk32, 1'b1);
    chk("unk_imm", imm32, 32'h0);
    chk("unk_fmt", fmt32, 3'd0);
    cycle(1'b1, 32'h800000B7, 5'd5, 1'b1, 1'b0);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt", fmt64, 3'd4);
    cycle(1'b1, 32'h03F09093, 5'd6, 1'b1, 1'b0);
    chk("slli_imm64", imm64, 64'd63);
    chk("slli_imm32", imm32, 32'd31);
    chk("slli_fmt", fmt64, 3'd6);
    idle(1'b1);
    idle(1'b1);

    // backpressure: third offer held until a pop frees a slot
    cycle(1'b1, 32'h00100093, 5'd1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 5'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300093, 5'd3, 1'b0, 1'b0);
    chk("full_rdy", rdy32, 1'b0);
    chk("full_head", tag32, 5'd1);
    cycle(1'b1, 32'h00300093, 5'd3, 1'b1, 1'b0);
    chk("pop_rdy", rdy32, 1'b1);
    chk("pop_head", tag32, 5'd2);
    cycle(1'b1, 32'h00300093, 5'd3, 1'b0, 1'b0);
    idle(1'b1);
    chk("order3", tag32, 5'd3);
    chk("order3_imm", imm32, 32'd3);
    idle(1'b1);
    idle(1'b1);

    // flush while full, with a push offered in the same cycle
    cycle(1'b1, 32'h00400093, 5'd4, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500093, 5'd5, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600093, 5'd6, 1'b1, 1'b1);
    chk("flush_vld", v32, 1'b0);
    chk("flush_rdy", rdy32, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // asynchronous reset between edges with two entries held
    cycle(1'b1, 32'h00700093, 5'd7, 1'b0, 1'b0);
    cycle(1'b1, 32'h00800093, 5'd8, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld32", v32, 1'b0);
    chk("arst_vld64", v64, 1'b0);
    chk("arst_rdy", rdy32, 1'b1);
    chk("arst_imm", imm64, 64'h0);
    q32.delete();
    q64.delete();
    m_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'hFFF00093, 5'd9, 1'b1, 1'b0);
    chk("post_rst_tag", tag32, 5'd9);
    chk("post_rst_imm", imm32, 32'hFFFFFFFF);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0,
            rnd_inst(),
            5'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_state();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts 32-bit instruction words under a valid/ready handshake and decodes them into an XLEN-wide sign-extended immediate plus a format code. Results are buffered in a small in-order queue so upstream fetch and downstream execute decouple under backpressure. Covers RV32I and RV64I, including AUIPC, shift-immediates and OP-IMM-32.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64.
DEPTH, 2, result queue entries; minimum 2.
TAG_W, 5, width of the sideband tag carried with each instruction.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous; discards all queued results.
in_valid  input  1  instruction offered.
in_ready  output  1  queue can accept.
in_inst  input  32  instruction word.
in_tag  input  TAG_W  sideband tag, returned unchanged.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
out_tag  output  TAG_W  tag of the presented result.
out_unknown  output  1  opcode not recognised.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset: queue empty. out_valid=0, out_imm=0, out_fmt=0, out_tag=0, out_unknown=0, in_ready=1.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Decode is combinational on in_inst and stored with the entry. Latency from push to out_valid is 1 cycle when the queue is empty.
- in_ready is registered: it is 1 iff count < DEPTH. In the cycle the queue is full, a simultaneous pop does not raise in_ready until the next cycle.
- Simultaneous push and pop: count is unchanged. Order is strict FIFO. Read/write pointers wrap modulo DEPTH.
- out_* fields are driven from the head entry. When the queue is empty, out_* hold 0.
- flush has priority over a same-cycle push and pop. The next cycle has count=0, out_valid=0 and in_ready=1, and the flushed push is lost.
- Decode, with sx() meaning sign-extend from bit 31 to XLEN:
  - inst[1:0] != 2'b11: unknown.
  - 0000011 load, 1100111 JALR: fmt I, sx(inst[31:20]).
  - 0010011 OP-IMM:
    - funct3 001/101: fmt SHAMT, zero-extended inst[24:20] for XLEN=32, inst[25:20] for XLEN=64.
    - otherwise: fmt I.
  - 0011011 OP-IMM-32, valid only for XLEN=64:
    - funct3 001/101: SHAMT from inst[24:20].
    - otherwise: fmt I.
    - For XLEN=32 this opcode decodes as unknown.
  - 0100011: fmt S, sx({inst[31:25],inst[11:7]}).
  - 1100011: fmt B, sx({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111 LUI, 0010111 AUIPC: fmt U, sx({inst[31:12],12'b0}).
  - 1101111: fmt J, sx({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Anything else: out_unknown=1, fmt NONE, imm 0. The entry is still queued and handshaken normally.
- Reset mid-operation: all entries are dropped at once (asynchronous). out_valid falls without waiting for a clock edge.

Test Plan:
- XLEN=32, push 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, tag echoed. Push 0xFE112E23 (sw -4) -> out_imm=0xFFFFFFFC, fmt=2.
- Push 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt=3. Push 0x0000000B -> out_unknown=1, imm=0, fmt=0.
- DEPTH=2 with out_ready=0: push tags 1, 2, then in_ready=0 and tag 3 is held. Pop once -> in_ready=1 one cycle later. Results emerge in order 1, 2, 3.
- XLEN=64: 0x800000B7 (lui 0x80000) -> 0xFFFFFFFF80000000, fmt=4. 0x03F09093 (slli 63) -> imm=63, fmt=6. The same slli word on XLEN=32 -> imm=31.
- Queue full, then flush asserted together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed word never appears.
- Queue holding 2 entries, drop rst_n between clock edges -> out_valid=0 immediately. After release, first push appears after 1 cycle with correct data.
